// File: rtl/controle_linha_brinquedo_pkg.sv
// Shared definitions for the toy production line controller:
// state codes, timer width and default station durations.
package controle_linha_brinquedo_pkg;

  localparam int unsigned TIMER_W = 4;

  // Default station durations, in ticks of the upstream time base
  localparam int unsigned T_PRENSA_PADRAO  = 2;
  localparam int unsigned T_PINTURA_PADRAO = 3;
  localparam int unsigned T_SECAGEM_PADRAO = 4;

  // Line states; code 7 is unused and recovers to ST_OCIOSO
  typedef enum logic [2:0] {
    ST_OCIOSO     = 3'd0,
    ST_ESTEIRA    = 3'd1,
    ST_PRENSA     = 3'd2,
    ST_PINTURA    = 3'd3,
    ST_SECAGEM    = 3'd4,
    ST_PRONTO     = 3'd5,
    ST_EMERGENCIA = 3'd6,
    ST_INVALIDO   = 3'd7
  } estado_t;

  // States whose duration is measured by the tick timer
  function automatic logic estado_temporizado(input estado_t e);
    return (e == ST_PRENSA) || (e == ST_PINTURA) || (e == ST_SECAGEM);
  endfunction

endpackage

// File: rtl/temporizador_ticks.sv
// Loadable 4-bit down-counter advanced by the tick enable.
// fim flags the last remaining tick (value == 1).
module temporizador_ticks
  import controle_linha_brinquedo_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               limpa,
  input  logic               carga,
  input  logic [TIMER_W-1:0] valor_carga,
  input  logic               conta,
  output logic               fim
);

  logic [TIMER_W-1:0] valor;

  // Load wins over counting, so a tick in the load cycle is not consumed
  always_ff @(posedge clk) begin
    if (reset || limpa)
      valor <= '0;
    else if (carga)
      valor <= valor_carga;
    else if (conta && (valor != '0))
      valor <= valor - 1'b1;
  end

  assign fim = (valor == TIMER_W'(1));

endmodule

// File: rtl/controle_linha_brinquedo.sv
// Toy production line controller: conveyor -> press -> paint -> dry ->
// finished pulse, with emergency stop and a saturating part counter.
module controle_linha_brinquedo
  import controle_linha_brinquedo_pkg::*;
#(
  parameter int unsigned T_PRENSA  = T_PRENSA_PADRAO,
  parameter int unsigned T_PINTURA = T_PINTURA_PADRAO,
  parameter int unsigned T_SECAGEM = T_SECAGEM_PADRAO
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       sensor_peca,
  input  logic       parada,
  output logic       motor_esteira,
  output logic       prensa,
  output logic       pintura,
  output logic       secador,
  output logic       pronto,
  output logic       alarme,
  output logic [2:0] estado,
  output logic [7:0] contagem_pecas
);

  estado_t            estado_q, estado_d;
  logic               tmr_carga, tmr_limpa, tmr_conta, tmr_fim;
  logic [TIMER_W-1:0] tmr_valor;

  temporizador_ticks u_tmr (
    .clk         (clk),
    .reset       (reset),
    .limpa       (tmr_limpa),
    .carga       (tmr_carga),
    .valor_carga (tmr_valor),
    .conta       (tmr_conta),
    .fim         (tmr_fim)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset)
      estado_q <= ST_OCIOSO;
    else
      estado_q <= estado_d;
  end

  // Next state and timer control; emergency stop overrides every other input
  always_comb begin
    estado_d  = estado_q;
    tmr_carga = 1'b0;
    tmr_limpa = 1'b0;
    tmr_valor = '0;
    if (parada) begin
      estado_d  = ST_EMERGENCIA;
      tmr_limpa = 1'b1;
    end else begin
      case (estado_q)
        ST_OCIOSO:
          if (start) estado_d = ST_ESTEIRA;
        ST_ESTEIRA:
          if (sensor_peca) begin
            estado_d  = ST_PRENSA;
            tmr_carga = 1'b1;
            tmr_valor = TIMER_W'(T_PRENSA);
          end
        ST_PRENSA:
          if (tick && tmr_fim) begin
            estado_d  = ST_PINTURA;
            tmr_carga = 1'b1;
            tmr_valor = TIMER_W'(T_PINTURA);
          end
        ST_PINTURA:
          if (tick && tmr_fim) begin
            estado_d  = ST_SECAGEM;
            tmr_carga = 1'b1;
            tmr_valor = TIMER_W'(T_SECAGEM);
          end
        ST_SECAGEM:
          if (tick && tmr_fim) estado_d = ST_PRONTO;
        ST_PRONTO:
          estado_d = start ? ST_ESTEIRA : ST_OCIOSO;
        ST_EMERGENCIA:
          if (!start) estado_d = ST_OCIOSO;
        default:
          estado_d = ST_OCIOSO;
      endcase
    end
    // Ticks only count inside timed states and never in a load cycle
    tmr_conta = tick && estado_temporizado(estado_q) && !tmr_carga && !parada;
  end

  // Moore outputs registered from the next state so they align with estado
  always_ff @(posedge clk) begin
    if (reset) begin
      motor_esteira <= 1'b0;
      prensa        <= 1'b0;
      pintura       <= 1'b0;
      secador       <= 1'b0;
      pronto        <= 1'b0;
      alarme        <= 1'b0;
    end else begin
      motor_esteira <= (estado_d == ST_ESTEIRA);
      prensa        <= (estado_d == ST_PRENSA);
      pintura       <= (estado_d == ST_PINTURA);
      secador       <= (estado_d == ST_SECAGEM);
      pronto        <= (estado_d == ST_PRONTO);
      alarme        <= (estado_d == ST_EMERGENCIA);
    end
  end

  // Finished-part counter, bumped on entry to PRONTO, saturating at 255
  always_ff @(posedge clk) begin
    if (reset)
      contagem_pecas <= '0;
    else if ((estado_d == ST_PRONTO) && (estado_q != ST_PRONTO) &&
             (contagem_pecas != 8'hFF))
      contagem_pecas <= contagem_pecas + 8'd1;
  end

  assign estado = estado_q;

endmodule

// File: tb/tb_controle_linha_brinquedo.sv
// Bench for controle_linha_brinquedo: scenario tasks plus randomized run,
// checked cycle by cycle against a behavioural model of the line.
module tb_controle_linha_brinquedo;

  localparam int TP = 2, TPI = 3, TS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, tick, start, sensor_peca, parada;
  logic       motor_esteira, prensa, pintura, secador, pronto, alarme;
  logic [2:0] estado;
  logic [7:0] contagem_pecas;

  // Second instance with 1-tick stations for the saturation run
  logic       s_reset, s_tick, s_start, s_sensor, s_parada;
  logic       s_motor, s_prensa, s_pintura, s_secador, s_pronto, s_alarme;
  logic [2:0] s_estado;
  logic [7:0] s_contagem;

  int checks = 0, errors = 0;

  // Model: phase code, remaining ticks of the current station, parts done
  int m_st = 0, m_rem = 0, m_cnt = 0;

  controle_linha_brinquedo #(.T_PRENSA(TP), .T_PINTURA(TPI), .T_SECAGEM(TS)) u_dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start),
    .sensor_peca(sensor_peca), .parada(parada),
    .motor_esteira(motor_esteira), .prensa(prensa), .pintura(pintura),
    .secador(secador), .pronto(pronto), .alarme(alarme),
    .estado(estado), .contagem_pecas(contagem_pecas)
  );

  controle_linha_brinquedo #(.T_PRENSA(1), .T_PINTURA(1), .T_SECAGEM(1)) u_sat (
    .clk(clk), .reset(s_reset), .tick(s_tick), .start(s_start),
    .sensor_peca(s_sensor), .parada(s_parada),
    .motor_esteira(s_motor), .prensa(s_prensa), .pintura(s_pintura),
    .secador(s_secador), .pronto(s_pronto), .alarme(s_alarme),
    .estado(s_estado), .contagem_pecas(s_contagem)
  );

  function automatic logic [16:0] esperado();
    return {m_st == 1, m_st == 2, m_st == 3, m_st == 4, m_st == 5, m_st == 6,
            3'(m_st), 8'(m_cnt)};
  endfunction

  function automatic logic [16:0] observado();
    return {motor_esteira, prensa, pintura, secador, pronto, alarme,
            estado, contagem_pecas};
  endfunction

  // Advance one clock and apply the line rules to the model
  task automatic step();
    @(posedge clk);
    if (reset) begin
      m_st = 0; m_rem = 0; m_cnt = 0;
    end else if (parada) begin
      m_st = 6; m_rem = 0;
    end else begin
      case (m_st)
        0: if (start) m_st = 1;
        1: if (sensor_peca) begin m_st = 2; m_rem = TP; end
        2, 3, 4: if (tick) begin
          m_rem = m_rem - 1;
          if (m_rem == 0) begin
            if (m_st == 2)      begin m_st = 3; m_rem = TPI; end
            else if (m_st == 3) begin m_st = 4; m_rem = TS; end
            else begin m_st = 5; if (m_cnt < 255) m_cnt = m_cnt + 1; end
          end
        end
        5: m_st = start ? 1 : 0;
        6: if (!start) m_st = 0;
        default: m_st = 0;
      endcase
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1; parada = 1; start = 1; sensor_peca = 1; tick = 1;
    s_reset = 1; s_parada = 0; s_start = 0; s_sensor = 0; s_tick = 0;
    step(); step();
    checks++;
    if (observado() !== 17'd0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", observado());
    end
    reset = 0; parada = 0; start = 0; sensor_peca = 0; tick = 0; s_reset = 0;
    step();
    checks++;
    if (observado() !== esperado()) begin
      errors++; $display("FAIL reset_idle: got %h want %h", observado(), esperado());
    end
  endtask

  task automatic test_ciclo_normal();
    int pulsos = 0;
    start = 1; step();
    sensor_peca = 1; step(); sensor_peca = 0;
    checks++;
    if (estado !== 3'd2) begin
      errors++; $display("FAIL normal_enter_prensa: got %0d want 2", estado);
    end
    for (int i = 0; i < 40; i++) begin
      tick = (i % 4 == 3);
      step();
      tick = 0;
      if (pronto) pulsos++;
      checks++;
      if (observado() !== esperado()) begin
        errors++; $display("FAIL normal_cycle%0d: got %h want %h", i, observado(), esperado());
      end
    end
    checks++;
    if (pulsos !== 1 || contagem_pecas !== 8'd1 || estado !== 3'd1) begin
      errors++;
      $display("FAIL normal_end: pulses %0d count %0d state %0d want 1 1 1",
               pulsos, contagem_pecas, estado);
    end
  endtask

  task automatic test_start_cai();
    int pulsos = 0;
    start = 1; sensor_peca = 1; step(); sensor_peca = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_st == 3) start = 0;
      tick = (i % 4 == 3);
      step();
      tick = 0;
      if (pronto) pulsos++;
      checks++;
      if (observado() !== esperado()) begin
        errors++; $display("FAIL start_drop_cycle%0d: got %h want %h", i, observado(), esperado());
      end
    end
    checks++;
    if (pulsos !== 1 || estado !== 3'd0 || contagem_pecas !== 8'd2) begin
      errors++;
      $display("FAIL start_drop_end: pulses %0d state %0d count %0d want 1 0 2",
               pulsos, estado, contagem_pecas);
    end
  endtask

  task automatic test_emergencia();
    bit achou = 0;
    start = 1; step();
    sensor_peca = 1; step(); sensor_peca = 0;
    for (int i = 0; i < 100 && !achou; i++) begin
      tick = (i % 4 == 3);
      step();
      tick = 0;
      checks++;
      if (observado() !== esperado()) begin
        errors++; $display("FAIL emerg_run%0d: got %h want %h", i, observado(), esperado());
      end
      if (m_st == 4 && m_rem == 2) achou = 1;
    end
    checks++;
    if (!achou) begin
      errors++; $display("FAIL emerg_reach_secagem: timed out, state %0d want 4", estado);
    end
    parada = 1; tick = 1; sensor_peca = 1; step();
    parada = 0; tick = 0; sensor_peca = 0;
    checks++;
    if (estado !== 3'd6 || alarme !== 1'b1 || secador !== 1'b0) begin
      errors++;
      $display("FAIL emerg_enter: state %0d alarme %b secador %b want 6 1 0",
               estado, alarme, secador);
    end
    start = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (estado !== 3'd6 || observado() !== esperado()) begin
        errors++; $display("FAIL emerg_hold%0d: got %h want %h", i, observado(), esperado());
      end
    end
    start = 0; step();
    checks++;
    if (estado !== 3'd0 || contagem_pecas !== 8'd2 || alarme !== 1'b0) begin
      errors++;
      $display("FAIL emerg_exit: state %0d count %0d alarme %b want 0 2 0",
               estado, contagem_pecas, alarme);
    end
  endtask

  task automatic test_tick_sensor();
    start = 1; step();
    sensor_peca = 1; tick = 1; step();
    sensor_peca = 0; tick = 0;
    checks++;
    if (estado !== 3'd2) begin
      errors++; $display("FAIL ticksens_enter: got %0d want 2", estado);
    end
    step(); step();
    tick = 1; step(); tick = 0;
    checks++;
    if (estado !== 3'd2 || prensa !== 1'b1) begin
      errors++; $display("FAIL ticksens_first_tick: state %0d prensa %b want 2 1", estado, prensa);
    end
    step();
    tick = 1; step(); tick = 0;
    checks++;
    if (estado !== 3'd3 || observado() !== esperado()) begin
      errors++; $display("FAIL ticksens_second_tick: got %h want %h", observado(), esperado());
    end
  endtask

  task automatic test_reset_parada();
    // Line is in PINTURA here
    checks++;
    if (estado !== 3'd3) begin
      errors++; $display("FAIL rstpar_pre: state %0d want 3", estado);
    end
    reset = 1; parada = 1; tick = 1; step();
    reset = 0; parada = 0; tick = 0; start = 0;
    checks++;
    if (observado() !== 17'd0) begin
      errors++; $display("FAIL rstpar_clear: got %h want 0", observado());
    end
  endtask

  task automatic test_aleatorio();
    for (int i = 0; i < 3000; i++) begin
      start       = ($urandom_range(0, 9) != 0);
      sensor_peca = ($urandom_range(0, 3) == 0);
      tick        = ($urandom_range(0, 2) == 0);
      parada      = ($urandom_range(0, 99) == 0);
      reset       = ($urandom_range(0, 499) == 0);
      step();
      checks++;
      if (observado() !== esperado()) begin
        errors++; $display("FAIL random%0d: got %h want %h", i, observado(), esperado());
      end
    end
    reset = 0; parada = 0; start = 0; sensor_peca = 0; tick = 0;
  endtask

  task automatic test_saturacao();
    int n = 0;
    int cyc = 0;
    s_start = 1; s_sensor = 1; s_tick = 1;
    while (n < 260 && cyc < 2000) begin
      step();
      cyc++;
      if (s_pronto) n++;
      checks++;
      if (s_contagem !== 8'((n > 255) ? 255 : n)) begin
        errors++; $display("FAIL sat_count_cyc%0d: got %0d want %0d", cyc, s_contagem,
                           (n > 255) ? 255 : n);
      end
    end
    s_start = 0; s_sensor = 0; s_tick = 0;
    checks++;
    if (n !== 260 || s_contagem !== 8'd255) begin
      errors++; $display("FAIL sat_end: parts %0d count %0d want 260 255", n, s_contagem);
    end
  endtask

  initial begin
    test_reset();
    test_ciclo_normal();
    test_start_cai();
    test_emergencia();
    test_tick_sensor();
    test_reset_parada();
    test_aleatorio();
    test_saturacao();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
